usbf_dma_arb: RTL and testbench

- Parametrised successor to the fixed 16-bit dma_req_o/dma_ack_i handshake of the USB function core.
- Arbitrates NCH endpoint DMA service requests from the register file onto an external DMA engine, round-robin.
- Handles per-grant burst counting, an ack timeout and abort handling; reports per-channel completion.
- Sits in the clk_i (WISHBONE) domain between usbf_rf and the dma_req_o/dma_ack_i pads.

---
 rtl/usbf_dma_pkg.sv | 25 ++
 rtl/usbf_dma_arb_if.sv | 35 +++
 rtl/usbf_dma_arb_rr_pick.sv | 38 +++
 rtl/usbf_dma_arb.sv | 151 +++++++++++++++
 tb/tb_usbf_dma_arb.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usbf_dma_pkg.sv
// -----------------------------------------------------------------------------
// usbf_dma_pkg
// Shared definitions for the endpoint DMA arbiter: FSM state encoding,
// default parameter values and a small wrap-around increment helper.
// -----------------------------------------------------------------------------
package usbf_dma_pkg;

    localparam int NCH_DEF     = 16;
    localparam int CH_W_DEF    = 4;
    localparam int BURST_W_DEF = 4;
    localparam int TO_W_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_REQ  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Next channel after idx, wrapping to 0 after n-1.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/usbf_dma_arb_if.sv
// -----------------------------------------------------------------------------
// usbf_dma_arb_if
// Bundles the arbiter's CSR inputs, the register-file need vector and the
// dma_req/dma_ack pad handshake.
//   master : the arbiter (drives dma_req_o and status pulses)
//   slave  : the environment (drives enable, need, config and acks)
// -----------------------------------------------------------------------------
interface usbf_dma_arb_if #(
    parameter int NCH     = 16,
    parameter int CH_W    = 4,
    parameter int BURST_W = 4,
    parameter int TO_W    = 8
);
    logic               en_i;
    logic [NCH-1:0]     ch_need_i;
    logic [BURST_W-1:0] burst_len_i;
    logic [TO_W-1:0]    to_limit_i;
    logic [NCH-1:0]     dma_ack_i;
    logic [NCH-1:0]     dma_req_o;
    logic [CH_W-1:0]    ch_idx_o;
    logic               busy_o;
    logic [NCH-1:0]     done_o;
    logic               to_err_o;
    logic               stray_ack_o;

    modport master (
        input  en_i, ch_need_i, burst_len_i, to_limit_i, dma_ack_i,
        output dma_req_o, ch_idx_o, busy_o, done_o, to_err_o, stray_ack_o
    );

    modport slave (
        output en_i, ch_need_i, burst_len_i, to_limit_i, dma_ack_i,
        input  dma_req_o, ch_idx_o, busy_o, done_o, to_err_o, stray_ack_o
    );
endinterface

// File: rtl/usbf_dma_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// usbf_rr_pick
// Combinational round-robin priority finder: returns the first set bit of
// need_i at or above ptr_i, wrapping from NCH-1 back to 0.
//   need_i  : request vector
//   ptr_i   : search start position (must be < NCH)
//   valid_o : some bit of need_i is set
//   idx_o   : index of the selected bit
// -----------------------------------------------------------------------------
module usbf_rr_pick #(
    parameter int NCH  = 16,
    parameter int CH_W = 4
) (
    input  logic [NCH-1:0]  need_i,
    input  logic [CH_W-1:0] ptr_i,
    output logic            valid_o,
    output logic [CH_W-1:0] idx_o
);

    logic [CH_W-1:0] cand;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        // Walk offsets from farthest to nearest; the nearest hit is written last.
        for (int i = NCH - 1; i >= 0; i--) begin
            cand = CH_W'((32'(ptr_i) + 32'(i)) % NCH);
            if (need_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/usbf_dma_arb.sv
// -----------------------------------------------------------------------------
// usbf_dma_arb
// Round-robin arbiter granting NCH endpoint DMA channels to one external DMA
// engine, with per-grant burst counting, ack timeout and enable abort.
//   clk_i : core (WISHBONE) clock
//   rst   : asynchronous active-low reset
//   bus   : usbf_dma_arb_if.master -- enable/need/config/ack in,
//           dma_req_o, ch_idx_o, busy_o, done_o, to_err_o, stray_ack_o out
// All outputs are registered.
// -----------------------------------------------------------------------------
module usbf_dma_arb
    import usbf_dma_pkg::*;
#(
    parameter int NCH     = NCH_DEF,
    parameter int CH_W    = CH_W_DEF,
    parameter int BURST_W = BURST_W_DEF,
    parameter int TO_W    = TO_W_DEF
) (
    input logic            clk_i,
    input logic            rst,
    usbf_dma_arb_if.master bus
);

    state_e             state_q,   state_d;
    logic [CH_W-1:0]    rr_ptr_q,  rr_ptr_d;
    logic [CH_W-1:0]    ch_idx_q,  ch_idx_d;
    logic [BURST_W:0]   rem_q,     rem_d;
    logic [TO_W-1:0]    to_cnt_q,  to_cnt_d;
    logic               abort_q,   abort_d;
    logic [NCH-1:0]     dma_req_q, dma_req_d;
    logic               busy_q,    busy_d;
    logic [NCH-1:0]     done_q,    done_d;
    logic               to_err_q,  to_err_d;
    logic               stray_q,   stray_d;

    logic               pick_valid;
    logic [CH_W-1:0]    pick_idx;
    logic               grant_ack;
    logic               grant_need;
    logic               timeout;

    usbf_rr_pick #(.NCH(NCH), .CH_W(CH_W)) u_pick (
        .need_i  (bus.ch_need_i),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign grant_ack  = bus.dma_ack_i[ch_idx_q];
    assign grant_need = bus.ch_need_i[ch_idx_q];
    assign timeout    = (bus.to_limit_i != '0) && (to_cnt_q == bus.to_limit_i - TO_W'(1));

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        ch_idx_d = ch_idx_q;
        rem_d    = rem_q;
        to_cnt_d = to_cnt_q;
        abort_d  = abort_q;
        to_err_d = 1'b0;
        done_d   = '0;
        // dma_req_q is the granted one-hot in REQ and zero elsewhere, so any
        // ack outside it is stray.
        stray_d  = |(bus.dma_ack_i & ~dma_req_q);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.en_i && |bus.ch_need_i) state_d = ST_ARB;
            end
            ST_ARB: begin
                to_cnt_d = '0;
                abort_d  = 1'b0;
                if (pick_valid) begin
                    ch_idx_d = pick_idx;
                    rem_d    = (bus.burst_len_i == '0) ? (BURST_W+1)'(1 << BURST_W)
                                                       : {1'b0, bus.burst_len_i};
                    state_d  = ST_REQ;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (grant_ack) begin
                    rem_d    = rem_q - (BURST_W+1)'(1);
                    to_cnt_d = '0;
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
                if ((grant_ack && rem_q == (BURST_W+1)'(1)) || !grant_need || !bus.en_i) begin
                    state_d = ST_DONE;
                    abort_d = !bus.en_i;
                end else if (!grant_ack && timeout) begin
                    // Skip past the stuck channel so it cannot starve the rest.
                    state_d  = ST_IDLE;
                    to_err_d = 1'b1;
                    rr_ptr_d = CH_W'(wrap_inc(32'(ch_idx_q), NCH));
                end
            end
            ST_DONE: begin
                rr_ptr_d = CH_W'(wrap_inc(32'(ch_idx_q), NCH));
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered against the next state so they line up with it.
        if (state_d == ST_DONE && !abort_d) done_d = NCH'(1) << ch_idx_q;
        dma_req_d = (state_d == ST_REQ) ? (NCH'(1) << ch_idx_d) : '0;
        busy_d    = (state_d == ST_REQ);
    end

    // NOTE: reset is asynchronous so dma_req_o drops the instant rst falls,
    // without waiting for a clock edge.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            ch_idx_q  <= '0;
            rem_q     <= '0;
            to_cnt_q  <= '0;
            abort_q   <= 1'b0;
            dma_req_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= '0;
            to_err_q  <= 1'b0;
            stray_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            ch_idx_q  <= ch_idx_d;
            rem_q     <= rem_d;
            to_cnt_q  <= to_cnt_d;
            abort_q   <= abort_d;
            dma_req_q <= dma_req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            to_err_q  <= to_err_d;
            stray_q   <= stray_d;
        end
    end

    assign bus.dma_req_o   = dma_req_q;
    assign bus.ch_idx_o    = ch_idx_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.to_err_o    = to_err_q;
    assign bus.stray_ack_o = stray_q;

endmodule

// File: tb/tb_usbf_dma_arb.sv
// -----------------------------------------------------------------------------
// tb_usbf_dma_arb
// Directed scenarios for usbf_dma_arb. Expected grant/done/timeout events are
// queued when a scenario starts and popped by a monitor as the DUT emits them.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_usbf_dma_arb;
    import usbf_dma_pkg::*;

    localparam int NCH     = 16;
    localparam int CH_W    = 4;
    localparam int BURST_W = 4;
    localparam int TO_W    = 8;

    localparam int EV_GRANT = 1;
    localparam int EV_DONE  = 2;
    localparam int EV_TOERR = 3;

    logic clk_i = 1'b0;
    logic rst   = 1'b0;
    always #5 clk_i = ~clk_i;

    usbf_dma_arb_if #(.NCH(NCH), .CH_W(CH_W), .BURST_W(BURST_W), .TO_W(TO_W)) bus ();

    usbf_dma_arb #(.NCH(NCH), .CH_W(CH_W), .BURST_W(BURST_W), .TO_W(TO_W)) dut (
        .clk_i (clk_i),
        .rst   (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ev(input int kind, input int ch);
        return kind * 32 + ch;
    endfunction

    function automatic int first_bit(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic sb_pop(input string tag, input int got);
        if (exp_q.size() == 0) check({tag, "_unexpected"}, got, 32'hFFFF_FFFF);
        else                   check(tag, got, exp_q.pop_front());
    endtask

    // Event monitor: grant = busy_o rising, plus done and timeout pulses.
    logic prev_busy = 1'b0;
    always @(negedge clk_i) begin
        if (bus.busy_o && !prev_busy) sb_pop("grant", ev(EV_GRANT, int'(bus.ch_idx_o)));
        if (bus.done_o != '0) begin
            check("done_onehot", $countones(bus.done_o), 1);
            sb_pop("done", ev(EV_DONE, first_bit(bus.done_o)));
        end
        if (bus.to_err_o) sb_pop("to_err", ev(EV_TOERR, int'(bus.ch_idx_o)));
        prev_busy <= bus.busy_o;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic push_burst(input int ch);
        exp_q.push_back(ev(EV_GRANT, ch));
        exp_q.push_back(ev(EV_DONE, ch));
    endtask

    // Hold need, ack every requested word, return after n_grants done pulses.
    task automatic serve(input logic [NCH-1:0] need, input logic [BURST_W-1:0] burst,
                         input int n_grants, output int acks, output logic [NCH-1:0] req_or);
        int ndone = 0;
        acks   = 0;
        req_or = '0;
        bus.ch_need_i   = need;
        bus.burst_len_i = burst;
        for (int i = 0; i < 400 && ndone < n_grants; i++) begin
            @(negedge clk_i);
            bus.dma_ack_i = bus.dma_req_o;
            req_or |= bus.dma_req_o;
            if (bus.dma_req_o != '0) acks++;
            if (bus.done_o != '0) ndone++;
        end
        bus.ch_need_i = '0;
        bus.dma_ack_i = '0;
        check("serve_budget", ndone, n_grants);
    endtask

    task automatic wait_req(input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (bus.dma_req_o != '0) begin seen = 1'b1; break; end
        end
        check(tag, seen, 1'b1);
    endtask

    initial begin
        int acks;
        int cnt;
        logic got;
        logic acked;
        logic [NCH-1:0] ro;

        bus.en_i        = 1'b0;
        bus.ch_need_i   = '0;
        bus.burst_len_i = '0;
        bus.to_limit_i  = '0;
        bus.dma_ack_i   = '0;
        idle(2);
        check("rst_req",    bus.dma_req_o, 0);
        check("rst_idx",    bus.ch_idx_o, 0);
        check("rst_busy",   bus.busy_o, 0);
        check("rst_done",   bus.done_o, 0);
        check("rst_to_err", bus.to_err_o, 0);
        check("rst_stray",  bus.stray_ack_o, 0);
        rst = 1'b1;
        bus.en_i = 1'b1;
        idle(2);

        // Single channel, burst of 4.
        push_burst(5);
        serve(16'h0020, 4'd4, 1, acks, ro);
        check("s1_acks", acks, 4);
        check("s1_req",  ro, 16'h0020);
        idle(2);

        // rr_ptr now 6: among 4,5,6 the order is 6, 4, 5.
        push_burst(6); push_burst(4); push_burst(5);
        serve(16'h0070, 4'd1, 3, acks, ro);
        check("s2_acks", acks, 3);
        check("s2_req",  ro, 16'h0070);
        idle(2);

        // Fairness between 0 and 3.
        push_burst(0); push_burst(3); push_burst(0); push_burst(3);
        serve(16'h0009, 4'd2, 4, acks, ro);
        check("s3_acks", acks, 8);
        idle(2);

        // Wrap 15 -> 0 (rr_ptr is 4 here).
        push_burst(15); push_burst(0);
        serve(16'h8001, 4'd1, 2, acks, ro);
        check("s4_acks", acks, 2);
        check("s4_req",  ro, 16'h8001);
        idle(2);

        // Timeout: ch 2 acks once then stalls, limit 8.
        exp_q.push_back(ev(EV_GRANT, 2));
        exp_q.push_back(ev(EV_TOERR, 2));
        bus.to_limit_i  = 8'd8;
        bus.burst_len_i = 4'd4;
        bus.ch_need_i   = 16'h0004;
        acked = 1'b0; cnt = 0; got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (bus.to_err_o) begin got = 1'b1; break; end
            if (bus.dma_req_o != '0 && !acked) begin
                bus.dma_ack_i = bus.dma_req_o;
                acked = 1'b1;
            end else begin
                bus.dma_ack_i = '0;
                if (bus.dma_req_o != '0 && acked) cnt++;
            end
        end
        bus.ch_need_i = 16'h000C;
        check("to_seen",        got, 1'b1);
        check("to_idle_cycles", cnt, 8);
        check("to_req_low",     bus.dma_req_o, 0);
        bus.to_limit_i = '0;
        push_burst(3);
        serve(16'h000C, 4'd4, 1, acks, ro);
        check("to_next_req", ro, 16'h0008);
        idle(2);

        // burst_len 0 means 16 words.
        push_burst(4);
        serve(16'h0010, 4'd0, 1, acks, ro);
        check("b0_acks", acks, 16);
        idle(2);

        // Early end: need drops after 3 of 8 acks.
        push_burst(5);
        bus.burst_len_i = 4'd8;
        bus.ch_need_i   = 16'h0020;
        cnt = 0; acks = 0; got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            if (bus.done_o != '0) begin got = 1'b1; break; end
            if (bus.dma_req_o != '0) cnt++;
            if (bus.dma_req_o != '0 && acks < 3) begin
                bus.dma_ack_i = bus.dma_req_o;
                acks++;
            end else begin
                bus.dma_ack_i = '0;
                if (acks == 3) bus.ch_need_i = '0;
            end
        end
        bus.dma_ack_i = '0;
        bus.ch_need_i = '0;
        check("early_done",     got, 1'b1);
        check("early_req_cyc",  cnt, 4);
        idle(2);

        // Stray acks while ch 1 is granted (rr_ptr 6 wraps to 1).
        push_burst(1);
        bus.burst_len_i = 4'd2;
        bus.ch_need_i   = 16'h0002;
        wait_req("st_req_up");
        check("st_req_ch1", bus.dma_req_o, 16'h0002);
        bus.dma_ack_i = 16'h0080;
        @(negedge clk_i);
        check("st_stray_a", bus.stray_ack_o, 1'b1);
        check("st_req_a",   bus.dma_req_o, 16'h0002);
        bus.dma_ack_i = 16'h0082;
        @(negedge clk_i);
        check("st_stray_b", bus.stray_ack_o, 1'b1);
        check("st_req_b",   bus.dma_req_o, 16'h0002);
        bus.dma_ack_i = 16'h0002;
        @(negedge clk_i);
        check("st_req_end", bus.dma_req_o, 0);
        check("st_done",    bus.done_o, 16'h0002);
        check("st_stray_c", bus.stray_ack_o, 1'b0);
        bus.dma_ack_i = 16'h0002;
        bus.ch_need_i = '0;
        @(negedge clk_i);
        check("st_late_ack", bus.stray_ack_o, 1'b1);
        bus.dma_ack_i = '0;
        idle(2);

        // en_i dropped mid-burst on ch 3: abort, no done.
        exp_q.push_back(ev(EV_GRANT, 3));
        bus.burst_len_i = 4'd4;
        bus.ch_need_i   = 16'h0008;
        wait_req("ab_req_up");
        bus.dma_ack_i = bus.dma_req_o;
        @(negedge clk_i);
        bus.dma_ack_i = bus.dma_req_o;
        @(negedge clk_i);
        bus.dma_ack_i = '0;
        bus.en_i      = 1'b0;
        @(negedge clk_i);
        check("ab_req_low", bus.dma_req_o, 0);
        check("ab_busy",    bus.busy_o, 1'b0);
        bus.ch_need_i = '0;
        idle(3);
        check("ab_idx_hold", bus.ch_idx_o, 3);
        bus.en_i = 1'b1;

        // Reset during REQ on ch 6 (rr_ptr 4).
        exp_q.push_back(ev(EV_GRANT, 6));
        bus.ch_need_i = 16'h0040;
        wait_req("rs_req_up");
        bus.dma_ack_i = bus.dma_req_o;
        @(negedge clk_i);
        #2 rst = 1'b0;
        #1;
        check("rs_req_async",  bus.dma_req_o, 0);
        check("rs_busy_async", bus.busy_o, 1'b0);
        bus.dma_ack_i = '0;
        bus.ch_need_i = 16'h0041;
        @(negedge clk_i);
        push_burst(0);
        rst = 1'b1;
        serve(16'h0041, 4'd1, 1, acks, ro);
        check("rs_first_ch", ro, 16'h0001);
        idle(3);

        check("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
